// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the RV32I multi-cycle control sequencer:
//   - base opcode constants (instruction bits [6:0])
//   - next-PC source encodings, also used by the program counter block
//   - sequencer state encoding
//   - trap cause codes
//   - opcode classification helpers
// No ports (package).
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

  // Base opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Next-PC source select
  localparam logic [1:0] PJUMP_PC4 = 2'b00;
  localparam logic [1:0] PJUMP_IMM = 2'b01;
  localparam logic [1:0] PJUMP_ALU = 2'b10;

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  // True for the nine RV32I base opcodes this core executes.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Stores and branches are the only legal instructions without a destination.
  function automatic logic writes_rd(input logic [6:0] op);
    return (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
// Request/acknowledge handshake between the sequencer and the instruction
// and data memories.
//   imem_req  sequencer -> imem : instruction fetch request
//   imem_ack  imem -> sequencer : instruction data valid
//   dmem_req  sequencer -> dmem : data access request
//   dmem_we   sequencer -> dmem : data access is a write
//   dmem_ack  dmem -> sequencer : data access complete
// master: the sequencer side; slave: the memory side.
// ----------------------------------------------------------------------------
interface pc_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond
// Combinational branch-condition evaluator.
//   funct3   in  3  branch type (instruction bits [14:12])
//   alu_zero in  1  rs1 == rs2
//   alu_lt   in  1  signed rs1 < rs2
//   alu_ltu  in  1  unsigned rs1 < rs2
//   taken    out 1  branch condition holds
//   illegal  out 1  funct3 is not a defined branch type (010, 011)
// ----------------------------------------------------------------------------
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  taken = alu_zero;   // BEQ
      3'b001:  taken = !alu_zero;  // BNE
      3'b100:  taken = alu_lt;     // BLT
      3'b101:  taken = !alu_lt;    // BGE
      3'b110:  taken = alu_ltu;    // BLTU
      3'b111:  taken = !alu_ltu;   // BGEU
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle control FSM for the RV32I core:
// FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH, with an absorbing TRAP.
// Parameters:
//   WAIT_LIMIT  max cycles a memory request waits for its ack
//   CNT_W       wait counter width, 2**CNT_W > WAIT_LIMIT
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   opcode, funct3    fields from the instruction register
//   alu_zero/lt/ltu   ALU compare flags for branches
//   bus               memory handshakes (pc_sequencer_if.master)
//   ir_load           load the instruction register
//   reg_we, pc_we     register file / PC write enables
//   jump, jump_sel    non-sequential next PC and its source
//   trap, trap_cause  sticky halt and its reason
// ----------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  pc_sequencer_if.master       bus,
  output logic                 ir_load,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic                 jump,
  output logic [1:0]           jump_sel,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  // The wait that ends on this cycle without an ack is the timeout.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(WAIT_LIMIT);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_taken;
  logic [1:0]       r_cause;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_taken_nxt;
  logic [1:0]       w_cause_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_br_taken;
  logic             w_br_illegal;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_is_branch;
  logic             w_is_jal;
  logic             w_is_jalr;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);

  branch_cond u_branch_cond (
    .funct3  (funct3),
    .alu_zero(alu_zero),
    .alu_lt  (alu_lt),
    .alu_ltu (alu_ltu),
    .taken   (w_br_taken),
    .illegal (w_br_illegal)
  );

  // Saturating wait counter; an ack in the timeout cycle still wins.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (r_cnt >= LAST_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_taken_nxt = r_taken;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DECODE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout) begin
            w_state_nxt = ST_TRAP;
            w_cause_nxt = CAUSE_IMEM_TO;
          end
        end
      end
      ST_DECODE: begin
        if (is_legal_op(opcode)) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        w_taken_nxt = w_is_branch & w_br_taken;
        if (w_is_branch && w_br_illegal) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = ST_MEM;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WB;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout) begin
            w_state_nxt = ST_TRAP;
            w_cause_nxt = CAUSE_DMEM_TO;
          end
        end
      end
      ST_WB:   w_state_nxt = ST_FETCH;
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
      r_cnt   <= '0;
      r_taken <= 1'b0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_taken <= w_taken_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Outputs decode from registered state; ir_load alone follows the ack
  // directly and is held low while reset is asserted.
  always_comb begin
    bus.imem_req = (r_state == ST_FETCH);
    bus.dmem_req = (r_state == ST_MEM);
    bus.dmem_we  = (r_state == ST_MEM) & w_is_store;
    ir_load      = (r_state == ST_FETCH) & bus.imem_ack & rst;
    pc_we        = (r_state == ST_WB);
    reg_we       = (r_state == ST_WB) & writes_rd(opcode);
    jump         = 1'b0;
    jump_sel     = PJUMP_PC4;
    if (r_state == ST_WB) begin
      if (w_is_jal) begin
        jump     = 1'b1;
        jump_sel = PJUMP_IMM;
      end else if (w_is_jalr) begin
        jump     = 1'b1;
        jump_sel = PJUMP_ALU;
      end else if (w_is_branch && r_taken) begin
        jump     = 1'b1;
        jump_sel = PJUMP_IMM;
      end
    end
    trap       = (r_state == ST_TRAP);
    trap_cause = r_cause;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer (WAIT_LIMIT = 4). Each instruction is
// described at transaction level (opcode, funct3, operand values, ack delays)
// and expanded into the per-cycle outputs it must produce; one compare
// process checks the DUT against that expectation every cycle.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int LIMIT = 4;
  localparam int CW    = 3;

  typedef logic [11:0] ovec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero, alu_lt, alu_ltu;
  logic       ir_load, reg_we, pc_we, jump, trap;
  logic [1:0] jump_sel, trap_cause;

  pc_sequencer_if mem_bus ();

  pc_sequencer #(.WAIT_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .alu_ltu   (alu_ltu),
    .bus       (mem_bus),
    .ir_load   (ir_load),
    .reg_we    (reg_we),
    .pc_we     (pc_we),
    .jump      (jump),
    .jump_sel  (jump_sel),
    .trap      (trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // {imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_we, jump, jump_sel, trap, trap_cause}
  function automatic ovec_t mkvec(bit imr, bit irl, bit drq, bit dwe, bit rwe, bit pcw,
                                  bit jmp, bit [1:0] sel, bit trp, bit [1:0] cs);
    return {imr, irl, drq, dwe, rwe, pcw, jmp, sel, trp, cs};
  endfunction

  function automatic ovec_t dut_vec();
    return {mem_bus.imem_req, ir_load, mem_bus.dmem_req, mem_bus.dmem_we, reg_we, pc_we,
            jump, jump_sel, trap, trap_cause};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  ovec_t expq[$];
  bit    armed = 1'b0;

  // Single compare process: one expected vector per clock cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL expect_queue_empty t=%0t actual=empty required=entry", $time);
      end else begin
        ovec_t e;
        e = expq.pop_front();
        chk("cycle_outputs", 32'(dut_vec()), 32'(e));
      end
    end
  end

  // Observed pulse counters and the last writeback decision.
  int         n_pcwe = 0, n_irl = 0, n_dreq = 0, n_dwe = 0;
  logic [3:0] last_wb = 4'h0;  // {reg_we, jump, jump_sel}
  always @(negedge clk) begin
    if (pc_we)           begin n_pcwe++; last_wb <= {reg_we, jump, jump_sel}; end
    if (ir_load)         n_irl++;
    if (mem_bus.dmem_req) n_dreq++;
    if (mem_bus.dmem_we)  n_dwe++;
  end

  // Model state
  bit       m_trapped = 1'b0;
  bit [1:0] m_cause   = 2'b00;
  int       m_retired = 0;
  int       cyc       = 0;

  task automatic rand_flags();
    alu_zero = rb();
    alu_lt   = rb();
    alu_ltu  = rb();
  endtask

  task automatic step(input logic iack, input logic dack, input ovec_t e);
    mem_bus.imem_ack = iack;
    mem_bus.dmem_ack = dack;
    expq.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asserted one time unit after an edge so the async path is visible
  // before the next clock.
  task automatic do_reset();
    rst = 1'b0;
    mem_bus.imem_ack = rb();
    mem_bus.dmem_ack = rb();
    expq.push_back(mkvec(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    #1;
    chk("async_rst_imem_req", 32'(mem_bus.imem_req), 1);
    chk("async_rst_dmem_req", 32'(mem_bus.dmem_req), 0);
    chk("async_rst_trap", 32'(trap), 0);
    @(posedge clk);
    #1;
    repeat (2) step(rb(), rb(), mkvec(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    rst       = 1'b1;
    m_trapped = 1'b0;
    m_cause   = 2'b00;
  endtask

  task automatic trap_cycles(input int n);
    repeat (n) begin
      rand_flags();
      step(rb(), rb(), mkvec(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, m_cause));
    end
  endtask

  // Run one instruction from its first FETCH cycle. fwait/mwait: cycles
  // before the ack (>= LIMIT means it never arrives in time). abort_mem:
  // MEM cycle number at which reset is pulled, 0 for none.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input int fwait, input int mwait, input int abort_mem,
                           output int ncyc);
    bit legal, ld, st, br, taken, got;
    bit jmp;
    bit [1:0] sel;
    int start;
    start = cyc;
    legal = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    br = (op == OP_BRANCH);
    opcode = op;
    funct3 = f3;
    ncyc   = 0;

    got = 1'b0;
    for (int c = 1; c <= LIMIT && !got; c++) begin
      rand_flags();
      if (c == fwait + 1) begin
        step(1'b1, rb(), mkvec(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        got = 1'b1;
      end else begin
        step(1'b0, rb(), mkvec(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
      end
    end
    if (!got) begin
      m_trapped = 1'b1; m_cause = CAUSE_IMEM_TO; ncyc = cyc - start; return;
    end

    rand_flags();
    step(rb(), rb(), mkvec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    if (!legal) begin
      m_trapped = 1'b1; m_cause = CAUSE_ILLEGAL; ncyc = cyc - start; return;
    end

    alu_zero = (a == b);
    alu_lt   = ($signed(a) < $signed(b));
    alu_ltu  = (a < b);
    step(rb(), rb(), mkvec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    taken = 1'b0;
    if (br) begin
      case (f3)
        3'b000: taken = (a == b);
        3'b001: taken = (a != b);
        3'b100: taken = ($signed(a) < $signed(b));
        3'b101: taken = ($signed(a) >= $signed(b));
        3'b110: taken = (a < b);
        3'b111: taken = (a >= b);
        default: begin
          m_trapped = 1'b1; m_cause = CAUSE_ILLEGAL; ncyc = cyc - start; return;
        end
      endcase
    end

    if (ld || st) begin
      got = 1'b0;
      for (int c = 1; c <= LIMIT && !got; c++) begin
        if (c == abort_mem) begin
          do_reset();
          ncyc = cyc - start;
          return;
        end
        rand_flags();
        if (c == mwait + 1) begin
          step(rb(), 1'b1, mkvec(0, 0, 1, st, 0, 0, 0, 2'b00, 0, 2'b00));
          got = 1'b1;
        end else begin
          step(rb(), 1'b0, mkvec(0, 0, 1, st, 0, 0, 0, 2'b00, 0, 2'b00));
        end
      end
      if (!got) begin
        m_trapped = 1'b1; m_cause = CAUSE_DMEM_TO; ncyc = cyc - start; return;
      end
    end

    jmp = (op == OP_JAL) || (op == OP_JALR) || (br && taken);
    sel = (op == OP_JALR) ? PJUMP_ALU : (jmp ? PJUMP_IMM : PJUMP_PC4);
    rand_flags();
    step(rb(), rb(), mkvec(0, 0, 0, 0, !(st || br), 1, jmp, sel, 0, 2'b00));
    m_retired++;
    ncyc = cyc - start;
  endtask

  int n, s_pc, s_irl, s_dreq, s_dwe, s_ret;
  logic [6:0] ops[9] = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  initial begin
    mem_bus.imem_ack = 1'b0;
    mem_bus.dmem_ack = 1'b0;
    opcode = 7'h00; funct3 = 3'h0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_imem_req", 32'(mem_bus.imem_req), 1);
    chk("reset_outputs_low", 32'({ir_load, mem_bus.dmem_req, reg_we, pc_we, jump, trap}), 0);
    chk("reset_trap_cause", 32'(trap_cause), 0);
    armed = 1'b1;
    do_reset();

    // ALU op, ack on the second FETCH cycle: back in FETCH on cycle 6.
    s_pc = n_pcwe; s_irl = n_irl;
    run_instr(OP_R, 3'b000, 32'd1, 32'd2, 1, 0, 0, n);
    chk("alu_latency", 32'(n), 5);
    chk("alu_irload_pulses", 32'(n_irl - s_irl), 1);
    chk("alu_pcwe_pulses", 32'(n_pcwe - s_pc), 1);
    chk("alu_wb", 32'(last_wb), 32'b1000);
    chk("alu_back_in_fetch", 32'(mem_bus.imem_req), 1);

    // BEQ taken / not taken
    run_instr(OP_BRANCH, 3'b000, 32'd7, 32'd7, 0, 0, 0, n);
    chk("beq_taken_wb", 32'(last_wb), 32'b0101);
    run_instr(OP_BRANCH, 3'b000, 32'd7, 32'd9, 0, 0, 0, n);
    chk("beq_not_taken_wb", 32'(last_wb), 32'b0000);

    // Load with ack 3 cycles late, then a store
    s_dreq = n_dreq; s_dwe = n_dwe;
    run_instr(OP_LOAD, 3'b010, 32'd0, 32'd0, 0, 3, 0, n);
    chk("load_latency", 32'(n), 8);
    chk("load_dmem_req_cycles", 32'(n_dreq - s_dreq), 4);
    chk("load_dmem_we_cycles", 32'(n_dwe - s_dwe), 0);
    chk("load_wb", 32'(last_wb), 32'b1000);
    s_dwe = n_dwe;
    run_instr(OP_STORE, 3'b010, 32'd0, 32'd0, 0, 0, 0, n);
    chk("store_dmem_we_cycles", 32'(n_dwe - s_dwe), 1);
    chk("store_wb", 32'(last_wb), 32'b0000);

    // JALR, then an illegal opcode and a reset out of TRAP
    run_instr(OP_JALR, 3'b000, 32'd0, 32'd0, 0, 0, 0, n);
    chk("jalr_wb", 32'(last_wb), 32'b1110);
    s_pc = n_pcwe;
    run_instr(7'b0000000, 3'b000, 32'd0, 32'd0, 0, 0, 0, n);
    trap_cycles(3);
    chk("illegal_trap", 32'(trap), 1);
    chk("illegal_cause", 32'(trap_cause), 1);
    chk("illegal_no_pcwe", 32'(n_pcwe - s_pc), 0);
    do_reset();
    chk("post_trap_reset_cause", 32'(trap_cause), 0);

    // Data memory never acks: trap after exactly LIMIT MEM cycles
    s_dreq = n_dreq; s_pc = n_pcwe;
    run_instr(OP_LOAD, 3'b000, 32'd0, 32'd0, 0, 99, 0, n);
    trap_cycles(2);
    chk("dmem_to_req_cycles", 32'(n_dreq - s_dreq), 4);
    chk("dmem_to_cause", 32'(trap_cause), 3);
    chk("dmem_to_no_pcwe", 32'(n_pcwe - s_pc), 0);
    do_reset();

    // Ack on the last permitted cycle completes normally
    s_pc = n_pcwe;
    run_instr(OP_STORE, 3'b000, 32'd0, 32'd0, 0, LIMIT - 1, 0, n);
    chk("ack_at_limit_no_trap", 32'(trap), 0);
    chk("ack_at_limit_pcwe", 32'(n_pcwe - s_pc), 1);

    // Fetch timeout, illegal branch funct3
    run_instr(OP_R, 3'b000, 32'd0, 32'd0, 99, 0, 0, n);
    trap_cycles(2);
    chk("imem_to_cause", 32'(trap_cause), 2);
    do_reset();
    run_instr(OP_BRANCH, 3'b010, 32'd0, 32'd0, 0, 0, 0, n);
    trap_cycles(1);
    chk("bad_branch_cause", 32'(trap_cause), 1);
    do_reset();

    // Reset in the middle of MEM: no writeback
    s_pc = n_pcwe;
    run_instr(OP_LOAD, 3'b000, 32'd0, 32'd0, 0, 3, 2, n);
    chk("mid_mem_reset_no_pcwe", 32'(n_pcwe - s_pc), 0);

    // Randomized instruction stream
    s_pc = n_pcwe; s_ret = m_retired;
    for (int i = 0; i < 200; i++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      int k, fw, mw, ab;
      k  = $urandom_range(0, 10);
      op = (k < 9) ? ops[k] : ((k == 9) ? 7'($urandom) : OP_BRANCH);
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      fw = ($urandom_range(0, 19) == 0) ? LIMIT + 1 : $urandom_range(0, LIMIT - 1);
      mw = ($urandom_range(0, 19) == 0) ? LIMIT + 1 : $urandom_range(0, LIMIT - 1);
      ab = ($urandom_range(0, 24) == 0) ? $urandom_range(1, LIMIT) : 0;
      run_instr(op, 3'($urandom), a, b, fw, mw, ab, n);
      if (m_trapped) begin
        trap_cycles($urandom_range(1, 3));
        do_reset();
      end
    end
    chk("random_retired_count", 32'(n_pcwe - s_pc), 32'(m_retired - s_ret));

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory and writeback.
- Tells the program counter when to advance (pc_we) and which next-PC source to use (jump, jump_sel).
- Evaluates branch conditions from ALU flags and supervises memory handshakes with a timeout trap.

Parameters:
- WAIT_LIMIT, 255, maximum cycles a memory request may wait for an ack before a bus-error trap.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction bits [6:0], taken from the instruction register.
- funct3  in  3  instruction bits [14:12].
- alu_zero  in  1  ALU result equals zero (rs1 == rs2 on compare).
- alu_lt  in  1  signed rs1 < rs2.
- alu_ltu  in  1  unsigned rs1 < rs2.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (stores).
- reg_we  out  1  register file write enable.
- pc_we  out  1  PC update enable.
- jump  out  1  select a non-sequential next PC.
- jump_sel  out  2  next-PC source: 00 pc+4, 01 PC+imm, 10 ALU result.
- trap  out  1  sticky halt indication.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

Behaviour:
- Reset (rst low, asynchronous):
  - state = FETCH, wait counter = 0, taken_q = 0, trap = 0, trap_cause = 00.
  - All outputs are Moore-decoded from registered state, so every output except imem_req is 0 during reset; imem_req = 1.
- Reset mid-operation aborts the current instruction immediately; there is no partial writeback.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - imem_req = 1; the counter increments each cycle.
  - imem_ack: ir_load = 1 in the same cycle (combinational from ack), counter clears, go to DECODE.
  - Counter reaching WAIT_LIMIT without ack: go to TRAP with cause 10.
- DECODE: one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: go to TRAP with cause 01. Otherwise go to EXEC.
- EXEC: one cycle.
  - Branch: taken_q <= per funct3: 000 alu_zero, 001 !alu_zero, 100 alu_lt, 101 !alu_lt, 110 alu_ltu, 111 !alu_ltu.
  - Branch with funct3 010 or 011: TRAP, cause 01.
  - Load or store: go to MEM. All others: go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for stores.
  - Hold until dmem_ack, then counter clears and go to WB.
  - Timeout at WAIT_LIMIT: TRAP, cause 11.
- WB: one cycle.
  - pc_we = 1.
  - reg_we = 1 for R, I-ALU, load, JAL, JALR, LUI, AUIPC; reg_we = 0 for store and branch.
  - jump/jump_sel: JAL 1/01; JALR 1/10; taken branch 1/01; otherwise 0/00.
  - Next state FETCH.
- TRAP:
  - Absorbing; only reset exits.
  - trap = 1, cause held; all request and enable outputs are 0.
- Counter and acks:
  - The counter saturates and never wraps.
  - An ack arriving in the same cycle the limit is reached wins: the access completes, no trap.
  - Ack outside FETCH or MEM is ignored.
- Latency: ALU instruction = 4 cycles + fetch wait; load/store = 5 cycles + both waits. Exactly one pc_we pulse per retired instruction.

Decomposition:
- Shared package holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - jump_sel encodings PJUMP_PC4 = 00, PJUMP_IMM = 01, PJUMP_ALU = 10, shared with the program counter;
  - state encoding;
  - trap cause codes.
- One natural sub-module, branch_cond: purely combinational, funct3 plus flags in, taken and illegal out.

Test Plan:
- Release reset, opcode 0110011, imem_ack on the 2nd FETCH cycle: ir_load pulses once, then DECODE, EXEC, WB with reg_we = 1, pc_we = 1, jump = 0; back to FETCH on the 6th cycle.
- BEQ (1100011, funct3 000) with alu_zero = 1: in WB, jump = 1 and jump_sel = 01. Repeat with alu_zero = 0: jump = 0. Both cases reg_we = 0.
- Load (0000011), dmem_ack delayed 3 cycles: dmem_req high 4 cycles, dmem_we = 0, then WB with reg_we = 1. Store (0100011): dmem_we = 1, reg_we = 0.
- JALR (1100111): in WB, jump = 1, jump_sel = 10, reg_we = 1. Opcode 0000000: TRAP with trap_cause = 01 and no pc_we pulse.
- Never assert dmem_ack, WAIT_LIMIT = 4: TRAP with cause 11 after 4 MEM cycles. Ack on exactly the 4th cycle: no trap, proceed to WB.
- Pull rst low mid-MEM and mid-TRAP: state returns to FETCH asynchronously, trap = 0, dmem_req = 0, imem_req = 1.
